// File: rtl/slice_reassembler_pkg.sv
// Shared types and helpers for the slice reassembler.
// Imported by the top level and its sub-module.
package slice_reassembler_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } state_e;

   // Number of slices that make up one word.
   function automatic int calc_n(input int ww, input int sw);
      return ww / sw;
   endfunction

   // Slice index width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/slice_reassembler_sat_counter.sv
// Saturating up-counter used for the framing-error tally.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: step on inc unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/slice_reassembler.sv
// Reassembles narrow link slices into wide words.
// Flags framing errors and resyncs on the next last-marker.
module slice_reassembler
   import slice_reassembler_pkg::*;
#(
   parameter int WORD_WIDTH      = 4,
   parameter int SLICE_WIDTH     = 2,
   parameter int ERR_COUNT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SLICE_WIDTH-1:0]     in_slice,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORD_WIDTH-1:0]      out_word,
   output logic                       err_pulse,
   output logic [ERR_COUNT_WIDTH-1:0] err_count
);

   localparam int N  = calc_n(WORD_WIDTH, SLICE_WIDTH);
   localparam int IW = idx_width(N);
   localparam int LW = WORD_WIDTH - SLICE_WIDTH;

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_e                state_q;
   state_e                state_d;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_d;
   logic [WORD_WIDTH-1:0] shadow_q;
   logic [WORD_WIDTH-1:0] shadow_d;
   logic [WORD_WIDTH-1:0] out_word_q;
   logic [WORD_WIDTH-1:0] out_word_d;
   logic                  out_valid_q;
   logic                  out_valid_d;
   logic                  err_pulse_q;
   logic                  err_pulse_d;

   logic accept;
   logic take;

   // Ready depends only on state, reset and consumer readiness.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         in_ready = (state_q == HOLD) ? out_ready : 1'b1;
      end
   end

   assign accept = in_valid && in_ready;

   // Next-state, assembly and framing-error detection.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      err_pulse_d = 1'b0;
      take        = 1'b0;

      unique case (state_q)
         COLLECT: begin
            take = accept;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = COLLECT;
               take        = accept;
            end
         end
         DISCARD: begin
            if (accept && in_last) begin
               state_d = COLLECT;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = COLLECT;
            idx_d   = '0;
         end
      endcase

      // A slice taken from HOLD always lands at index 0.
      if (take) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
               out_word_d  = {in_slice, shadow_q[LW-1:0]};
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               err_pulse_d = 1'b1;
               state_d     = DISCARD;
            end
         end else if (in_last) begin
            err_pulse_d = 1'b1;
            idx_d       = '0;
            state_d     = COLLECT;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IW'(i)) begin
                  shadow_d[i*SLICE_WIDTH +: SLICE_WIDTH] = in_slice;
               end
            end
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         shadow_q    <= '0;
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   sat_counter #(
      .WIDTH (ERR_COUNT_WIDTH)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_pulse_d),
      .count (err_count)
   );

   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_slice_reassembler.sv
// Directed bench for slice_reassembler (4-bit words, 2-bit slices).
// Words are checked against a queue filled as stimulus is driven.
module tb_slice_reassembler;

   localparam int WW  = 4;
   localparam int SW  = 2;
   localparam int ECW = 2;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] in_slice;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_word;
   logic          err_pulse;
   logic [ECW-1:0] err_count;

   int checks   = 0;
   int failures = 0;
   int err_seen = 0;
   int err_base = 0;

   logic [WW-1:0] exp_q[$];

   slice_reassembler #(
      .WORD_WIDTH      (WW),
      .SLICE_WIDTH     (SW),
      .ERR_COUNT_WIDTH (ECW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_slice  (in_slice),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each delivered word pops the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(out_word), 32'hFFFF_FFFF);
         end else begin
            chk("word", 32'(out_word), 32'(exp_q.pop_front()));
         end
      end
      if (err_pulse) err_seen++;
   end

   // Present a slice and hold it until accepted (bounded wait).
   task automatic send(input logic [SW-1:0] s, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_slice = s;
      in_last  = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_slice  = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_word", 32'(out_word), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready_hi", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic two-slice word
      exp_q.push_back(4'b1001);
      send(2'b01, 1'b0);
      send(2'b10, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_word", 32'(out_word), 32'h9);
      chk("basic_err", 32'(err_count), 32'd0);
      drain("basic_drain");
      @(posedge clk);
      #1;

      // Back-to-back with backpressure on the first word
      exp_q.push_back(4'hA);
      exp_q.push_back(4'h5);
      send(2'b10, 1'b0);
      send(2'b10, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_slice  = 2'b01;
      in_last   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_word", 32'(out_word), 32'hA);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(2'b01, 1'b0);
      send(2'b01, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_word", 32'(out_word), 32'h5);
      drain("b2b_drain");
      @(posedge clk);
      #1;

      // Short word at idx 0
      err_base = err_seen;
      send(2'b11, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("short_pulse", 32'(err_pulse), 32'd1);
      chk("short_count", 32'(err_count), 32'd1);
      chk("short_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("short_pulse_end", 32'(err_pulse), 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(4'h6);
      send(2'b10, 1'b0);
      send(2'b01, 1'b1);
      in_valid = 1'b0;
      drain("short_next");

      // Long word: error at second slice, rest discarded
      @(posedge clk);
      #1;
      send(2'b00, 1'b0);
      send(2'b00, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("long_pulse", 32'(err_pulse), 32'd1);
      chk("long_count", 32'(err_count), 32'd2);
      @(posedge clk);
      #1;
      send(2'b00, 1'b0);
      send(2'b00, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("long_no_valid", 32'(out_valid), 32'd0);
      chk("long_count_hold", 32'(err_count), 32'd2);
      chk("err_pulses_so_far", 32'(err_seen - err_base), 32'd2);
      @(posedge clk);
      #1;
      exp_q.push_back(4'h3);
      send(2'b11, 1'b0);
      send(2'b00, 1'b1);
      in_valid = 1'b0;
      drain("long_next");

      // Reset mid-word
      @(posedge clk);
      #1;
      err_base = err_seen;
      send(2'b01, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_pulse", 32'(err_pulse), 32'd0);
      chk("midrst_count", 32'(err_count), 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(4'hC);
      send(2'b00, 1'b0);
      send(2'b11, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrst_word", 32'(out_word), 32'hC);
      drain("midrst_drain");
      chk("midrst_no_err", 32'(err_seen - err_base), 32'd0);

      // Saturation of the 2-bit error counter
      @(posedge clk);
      #1;
      err_base = err_seen;
      for (int i = 0; i < 5; i++) begin
         send(2'b11, 1'b1);
         in_valid = 1'b0;
         @(negedge clk);
         chk("sat_pulse", 32'(err_pulse), 32'd1);
         chk("sat_count", 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("sat_pulse_total", 32'(err_seen - err_base), 32'd5);
      chk("sat_no_valid", 32'(out_valid), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/slice_reassembler.md
Name: slice_reassembler

Overview:
- Receive side of the sliced-bus link: accepts a stream of SLICE_WIDTH-bit slices from the slicing transmitter, tagged with a last-slice marker.
- Reassembles them by part-select writes into WORD_WIDTH-bit words, first slice at the LSBs, and presents each completed word on a valid/ready output.
- Detects framing errors, resynchronises on the next last-marker and counts errors.
- Sits between the serial link front-end and any wide-bus consumer.

Parameters:
- WORD_WIDTH, 4: assembled word width; must be an integer multiple of SLICE_WIDTH.
- SLICE_WIDTH, 2: incoming slice width.
- ERR_COUNT_WIDTH, 8: width of the saturating framing-error counter.
- Derived constant N = WORD_WIDTH/SLICE_WIDTH, with N >= 2 required. Slice index width is $clog2(N).

Ports:
- clk  input  1  clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  slice valid.
- in_ready  output  1  slice accepted when in_valid && in_ready.
- in_slice  input  SLICE_WIDTH  slice data.
- in_last  input  1  marks final slice of a word.
- out_valid  output  1  assembled word valid.
- out_ready  input  1  consumer ready.
- out_word  output  WORD_WIDTH  assembled word.
- err_pulse  output  1  one-cycle pulse per detected framing error.
- err_count  output  ERR_COUNT_WIDTH  saturating framing-error count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=COLLECT, idx=0, out_valid=0, out_word=0, err_pulse=0, err_count=0. in_ready is forced 0 while reset is high.
- FSM states:
  - COLLECT: in_ready=1. On accept at idx<N-1 with in_last=0: write shadow[idx*SLICE_WIDTH +: SLICE_WIDTH], idx++.
  - COLLECT, idx=N-1, in_last=1: out_word <= {in_slice, shadow[N-2 slices]}; out_valid <= 1; idx <= 0; go to HOLD.
  - COLLECT, in_last=1 at idx<N-1 (short word): err_pulse; word dropped; idx <= 0; stay in COLLECT.
  - COLLECT, in_last=0 at idx=N-1 (long word): err_pulse; word dropped; idx <= 0; go to DISCARD.
  - HOLD: out_valid=1; out_word stable. in_ready = out_ready.
  - HOLD, out_ready=1 and no slice accepted: out_valid <= 0, go to COLLECT.
  - HOLD, out_ready=1 and slice accepted: the slice is treated exactly as a COLLECT accept at idx 0, so back-to-back words lose no cycle. If that slice carries in_last=1, it is a short-word error.
  - DISCARD: in_ready=1; accepted slices are dropped. An accept with in_last=1 returns to COLLECT with idx=0. No further err_pulse is raised while in DISCARD.
- Latency: out_valid rises the cycle after the final slice is accepted. Sustained throughput is one word per N cycles.
- out_word changes only on word completion, never during partial assembly. Shadow contents are don't-care when out_valid=0.
- err_count: increments on each err_pulse and saturates at all-ones with no wrap. err_pulse is registered and lasts exactly one cycle.
- in_valid=0 never advances idx. Idle cycles mid-word are legal and hold state.
- Reset mid-word or mid-HOLD: the partial or held word is discarded with no output and no error. out_valid drops the cycle after reset is sampled.
- No combinational path from in_valid or in_slice to out_*. in_ready depends combinationally only on state, reset and out_ready.

Decomposition:
- Package slice_reassembler_pkg:
  - state enum {COLLECT, HOLD, DISCARD};
  - localparam function for N;
  - index-width helper.
- Sub-module sat_counter: parameterised width, inc input, saturating output; used for err_count.
- Everything else lives in slice_reassembler.

Test Plan (WORD_WIDTH=4, SLICE_WIDTH=2):
- Basic: reset, then slices 2'b01 (last=0) and 2'b10 (last=1), out_ready=1 -> out_valid=1 one cycle after second accept, out_word=4'b1001, err_count=0.
- Back-to-back with backpressure: words 4'hA and 4'h5 streamed continuously; out_ready=0 for 3 cycles on the first word -> in_ready=0 during the stall, out_word holds 4'hA. Release -> 4'hA then 4'h5 delivered in order, no gap beyond N cycles.
- Short word: slice 2'b11 with last=1 at idx 0 -> err_pulse for 1 cycle, err_count=1, no out_valid. Next two-slice word 4'h6 is delivered correctly.
- Long word: three slices with last=0, then one with last=1 -> single err_pulse at the second slice, DISCARD swallows the rest, no output. Following word 4'h3 is delivered.
- Saturation: with ERR_COUNT_WIDTH=2, inject 5 short words -> err_count sequence 1,2,3,3,3; err_pulse fires 5 times.
- Reset mid-word: accept one slice, assert reset for 1 cycle -> in_ready=0 during reset, no out_valid, no err_pulse. Subsequent word 4'hC is assembled from idx 0.
